// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg
// Shared types and constants for the rvseed pipeline sequencer.
//   - phc_state_e : sequencer state encodings
//   - phc_ctrl_t  : bundle of stage-register control outputs
//   - CTRL_*      : the fixed control patterns the sequencer emits
//   - PERF_CNT_W  : width of the optional stall-cycle counter
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_WIDTH_DFLT = 5;
  localparam int PERF_CNT_W          = 32;

  typedef enum logic [1:0] {
    PHC_INIT     = 2'd0,
    PHC_RUN      = 2'd1,
    PHC_MEM_WAIT = 2'd2,
    PHC_REDIRECT = 2'd3
  } phc_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifu2idu_en;
    logic ifu2idu_flush;
    logic idu2exu_en;
    logic idu2exu_bubble;
    logic exu2lsu_en;
  } phc_ctrl_t;

  // Field order: pc_en, ifu2idu_en, ifu2idu_flush, idu2exu_en, idu2exu_bubble, exu2lsu_en
  localparam phc_ctrl_t CTRL_INIT     = phc_ctrl_t'(6'b001010);
  localparam phc_ctrl_t CTRL_FREEZE   = phc_ctrl_t'(6'b000000);
  localparam phc_ctrl_t CTRL_FLOW     = phc_ctrl_t'(6'b110101);
  localparam phc_ctrl_t CTRL_REDIRECT = phc_ctrl_t'(6'b111111);
  localparam phc_ctrl_t CTRL_LOADUSE  = phc_ctrl_t'(6'b000111);

endpackage

// File: rtl/pipe_hazard_ctrl_cmp.sv
// pipe_hazard_cmp
// Purely combinational load-use detector: flags when the ID instruction
// reads a register that the load currently in EX will write.
// Ports:
//   exu_valid, exu_mem_ren, exu_reg_waddr : EX-slot load information
//   idu_reg{1,2}_ren, idu_reg{1,2}_raddr  : ID source operands
//   hazard                                : load-use hazard this cycle
module pipe_hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DFLT
) (
  input  logic                      exu_valid,
  input  logic                      exu_mem_ren,
  input  logic [REG_ADDR_WIDTH-1:0] exu_reg_waddr,
  input  logic                      idu_reg1_ren,
  input  logic [REG_ADDR_WIDTH-1:0] idu_reg1_raddr,
  input  logic                      idu_reg2_ren,
  input  logic [REG_ADDR_WIDTH-1:0] idu_reg2_raddr,
  output logic                      hazard
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = idu_reg1_ren && (idu_reg1_raddr == exu_reg_waddr);
    rs2_hit = idu_reg2_ren && (idu_reg2_raddr == exu_reg_waddr);
    // x0 is hard-wired zero, so a load targeting it never creates a dependency
    hazard  = exu_valid && exu_mem_ren && (exu_reg_waddr != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central pipeline sequencer for the rvseed core. Generates enable/bubble
// controls for PC, IFU2IDU, IDU2EXU and the EXU->LSU handoff, resolving
// load-use hazards, taken redirects and LSU wait-states.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   idu_reg{1,2}_ren/_raddr        : ID source operands
//   exu_valid/mem_ren/reg_waddr    : EX slot contents
//   exu_redirect                   : EX branch taken / jump
//   lsu_req, lsu_ack               : LSU access outstanding / completing
//   pc_en, ifu2idu_en, ifu2idu_flush, idu2exu_en, idu2exu_bubble,
//   exu2lsu_en                     : stage controls (combinational)
//   stall_cycles                   : only with HAZARD_PERF_CNT_EN defined;
//                                    saturating count of cycles with pc_en=0
// Build option: `define HAZARD_PERF_CNT_EN adds the stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH   = REG_ADDR_WIDTH_DFLT,
  parameter int REDIRECT_BUBBLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      idu_reg1_ren,
  input  logic [REG_ADDR_WIDTH-1:0] idu_reg1_raddr,
  input  logic                      idu_reg2_ren,
  input  logic [REG_ADDR_WIDTH-1:0] idu_reg2_raddr,
  input  logic                      exu_valid,
  input  logic                      exu_mem_ren,
  input  logic [REG_ADDR_WIDTH-1:0] exu_reg_waddr,
  input  logic                      exu_redirect,
  input  logic                      lsu_req,
  input  logic                      lsu_ack,
  output logic                      pc_en,
  output logic                      ifu2idu_en,
  output logic                      ifu2idu_flush,
  output logic                      idu2exu_en,
  output logic                      idu2exu_bubble,
  output logic                      exu2lsu_en
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0]     stall_cycles
`endif
);

  phc_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  phc_ctrl_t  ctrl;
  logic       hazard;
  logic       take_run_rules;

  pipe_hazard_cmp #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_cmp (
    .exu_valid      (exu_valid),
    .exu_mem_ren    (exu_mem_ren),
    .exu_reg_waddr  (exu_reg_waddr),
    .idu_reg1_ren   (idu_reg1_ren),
    .idu_reg1_raddr (idu_reg1_raddr),
    .idu_reg2_ren   (idu_reg2_ren),
    .idu_reg2_raddr (idu_reg2_raddr),
    .hazard         (hazard)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ctrl           = CTRL_FREEZE;
    take_run_rules = 1'b0;

    unique case (state_q)
      PHC_INIT: begin
        ctrl    = CTRL_INIT;
        state_d = PHC_RUN;
      end
      PHC_RUN: begin
        if (lsu_req && !lsu_ack) state_d = PHC_MEM_WAIT;
        else                     take_run_rules = 1'b1;
      end
      PHC_MEM_WAIT: begin
        // The ack cycle is a normal RUN cycle, so a redirect that sat in
        // EX during the wait is serviced here rather than dropped.
        if (lsu_ack) take_run_rules = 1'b1;
      end
      PHC_REDIRECT: begin
        // EX only holds bubbles here, so exu_redirect needs no attention.
        if (!(lsu_req && !lsu_ack)) begin
          ctrl  = CTRL_REDIRECT;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = PHC_RUN;
        end
      end
      default: state_d = PHC_INIT;
    endcase

    if (take_run_rules) begin
      state_d = PHC_RUN;
      if (exu_redirect && exu_valid) begin
        // Redirect beats load-use: the dependent ID instruction is flushed.
        ctrl = CTRL_REDIRECT;
        if (REDIRECT_BUBBLES > 1) begin
          cnt_d   = 4'(REDIRECT_BUBBLES - 1);
          state_d = PHC_REDIRECT;
        end
      end else if (hazard) begin
        ctrl = CTRL_LOADUSE;
      end else begin
        ctrl = CTRL_FLOW;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PHC_INIT;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_en          = ctrl.pc_en;
  assign ifu2idu_en     = ctrl.ifu2idu_en;
  assign ifu2idu_flush  = ctrl.ifu2idu_flush;
  assign idu2exu_en     = ctrl.idu2exu_en;
  assign idu2exu_bubble = ctrl.idu2exu_bubble;
  assign exu2lsu_en     = ctrl.exu2lsu_en;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (state_q != PHC_INIT && !ctrl.pc_en) stall_cycles_d = sat_inc(stall_cycles_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
